// File: rtl/vliw_ctrl_pkg.sv
// Shared encodings, control-field codes and the per-slot control bundle
// used by the VLIW ID/EX control stage.
package vliw_ctrl_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLTI = 3'b010;
  localparam logic [2:0] F3_SRLI = 3'b101;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [2:0] F3_CLW   = 3'b010;
  localparam logic [2:0] F3_CLUI  = 3'b011;
  localparam logic [2:0] F3_CBEQZ = 3'b110;
  localparam logic [2:0] F3_CBNEZ = 3'b111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_XOR = 2'b01;
  localparam logic [1:0] ALUOP_SHF = 2'b10;
  localparam logic [1:0] ALUOP_CMP = 2'b11;

  localparam logic [2:0] SRCB_RS2   = 3'b000;
  localparam logic [2:0] SRCB_SHAMT = 3'b001;
  localparam logic [2:0] SRCB_IMMI  = 3'b010;
  localparam logic [2:0] SRCB_IMMS  = 3'b011;
  localparam logic [2:0] SRCB_PC4   = 3'b100;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LINK = 2'b01;
  localparam logic [1:0] MEMTOREG_MEM  = 2'b10;

  localparam logic [1:0] PCSEL_SEQ    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_JUMP   = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       jump;
    logic       branch;
    logic       slti;
    logic [1:0] aluop;
    logic [2:0] alusrcb;
    logic [1:0] memtoreg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/vliw_ctrl_stage_slot_decoder.sv
// Combinational decoder for one issue slot: full (opcode+funct3) or
// compressed (quadrant+funct3) encoding to a control bundle plus illegal flag.
module slot_decoder
  import vliw_ctrl_pkg::*;
#(
  parameter bit COMPRESSED = 1'b0
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    if (COMPRESSED) begin
      // Only the quadrant bits are meaningful in a compressed slot.
      case ({opcode[1:0], funct3})
        {Q0, F3_CLW}: begin
          ctrl.regwrite = 1'b1;
          ctrl.memread  = 1'b1;
          ctrl.memtoreg = MEMTOREG_MEM;
          ctrl.alusrcb  = SRCB_IMMI;
        end
        {Q1, F3_CLUI}: begin
          ctrl.regwrite = 1'b1;
          ctrl.alusrcb  = SRCB_IMMI;
        end
        {Q1, F3_CBEQZ}, {Q1, F3_CBNEZ}: ctrl.branch = 1'b1;
        default: illegal = 1'b1;
      endcase
    end else begin
      case ({opcode, funct3})
        {OP_IMM, F3_ADDI}: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_ADD;
          ctrl.alusrcb  = SRCB_IMMI;
        end
        {OP_IMM, F3_SLTI}: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_CMP;
          ctrl.alusrcb  = SRCB_IMMI;
          ctrl.slti     = 1'b1;
        end
        {OP_IMM, F3_SRLI}: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_SHF;
          ctrl.alusrcb  = SRCB_SHAMT;
        end
        {OP_REG, F3_XOR}: begin
          ctrl.regwrite = 1'b1;
          ctrl.aluop    = ALUOP_XOR;
          ctrl.alusrcb  = SRCB_RS2;
        end
        {OP_JALR, F3_JALR}: begin
          ctrl.regwrite = 1'b1;
          ctrl.jump     = 1'b1;
          ctrl.memtoreg = MEMTOREG_LINK;
          ctrl.alusrcb  = SRCB_PC4;
        end
        {OP_STORE, F3_SW}: begin
          ctrl.memwrite = 1'b1;
          ctrl.alusrcb  = SRCB_IMMS;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vliw_ctrl_stage.sv
// ID/EX control stage: per-slot decode, intra-bundle squash, EX control
// register, redirect FSM driving pc_sel/if_flush, sticky illegal capture.
module vliw_ctrl_stage
  import vliw_ctrl_pkg::*;
#(
  parameter int                   NUM_SLOTS    = 2,
  parameter logic [NUM_SLOTS-1:0] COMP_MASK    = 2'b10,
  parameter int                   FLUSH_CYCLES = 1,
  localparam int                  SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SLOTS-1:0]     id_valid,
  input  logic [7*NUM_SLOTS-1:0]   id_opcode,
  input  logic [3*NUM_SLOTS-1:0]   id_funct3,
  input  logic                     stall,
  input  logic                     ex_br_taken,
  output logic [NUM_SLOTS-1:0]     ex_valid,
  output logic [NUM_SLOTS-1:0]     ex_regwrite,
  output logic [NUM_SLOTS-1:0]     ex_memwrite,
  output logic [NUM_SLOTS-1:0]     ex_memread,
  output logic [NUM_SLOTS-1:0]     ex_jump,
  output logic [NUM_SLOTS-1:0]     ex_branch,
  output logic [NUM_SLOTS-1:0]     ex_slti,
  output logic [2*NUM_SLOTS-1:0]   ex_aluop,
  output logic [3*NUM_SLOTS-1:0]   ex_alusrcb,
  output logic [2*NUM_SLOTS-1:0]   ex_memtoreg,
  output logic [1:0]               pc_sel,
  output logic                     if_flush,
  output logic                     illegal_err,
  output logic [SLOT_W-1:0]        illegal_slot,
  output logic                     fsm_state
);

  ctrl_bundle_t           dec_ctrl [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   dec_ill;
  ctrl_bundle_t           nxt_ctrl [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   nxt_valid;
  logic                   jalr_hit;
  logic                   ill_hit;
  logic [SLOT_W-1:0]      ill_idx;
  logic                   blocked;

  ctrl_bundle_t           ex_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   ex_valid_q;
  fsm_state_t             state;
  logic [2:0]             cnt;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_dec
    slot_decoder #(.COMPRESSED(COMP_MASK[g])) u_dec (
      .opcode  (id_opcode[7*g +: 7]),
      .funct3  (id_funct3[3*g +: 3]),
      .ctrl    (dec_ctrl[g]),
      .illegal (dec_ill[g])
    );
  end

  // The oldest valid jalr or illegal slot blocks every younger slot.
  always_comb begin
    nxt_valid = '0;
    jalr_hit  = 1'b0;
    ill_hit   = 1'b0;
    ill_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      nxt_ctrl[i] = CTRL_NOP;
      if (id_valid[i] && !blocked) begin
        if (dec_ill[i]) begin
          blocked = 1'b1;
          ill_hit = 1'b1;
          ill_idx = SLOT_W'(i);
        end else begin
          nxt_ctrl[i]  = dec_ctrl[i];
          nxt_valid[i] = 1'b1;
          if (dec_ctrl[i].jump) begin
            blocked  = 1'b1;
            jalr_hit = 1'b1;
          end
        end
      end
    end
  end

  // Redirect clears EX regardless of stall; wrong-path bundles during FLUSH load as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) ex_q[i] <= CTRL_NOP;
    end else if (ex_br_taken) begin
      ex_valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) ex_q[i] <= CTRL_NOP;
    end else if (!stall) begin
      if (state == ST_RUN) begin
        ex_valid_q <= nxt_valid;
        for (int i = 0; i < NUM_SLOTS; i++) ex_q[i] <= nxt_ctrl[i];
      end else begin
        ex_valid_q <= '0;
        for (int i = 0; i < NUM_SLOTS; i++) ex_q[i] <= CTRL_NOP;
      end
    end
  end

  // The flush counter runs through stalls so the IF squash window is fixed length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cnt      <= '0;
      pc_sel   <= PCSEL_SEQ;
      if_flush <= 1'b0;
    end else if (ex_br_taken) begin
      state    <= ST_FLUSH;
      cnt      <= 3'(FLUSH_CYCLES);
      pc_sel   <= PCSEL_BRANCH;
      if_flush <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall && jalr_hit) begin
            state    <= ST_FLUSH;
            cnt      <= 3'(FLUSH_CYCLES);
            pc_sel   <= PCSEL_JUMP;
            if_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt <= 3'd1) begin
            state    <= ST_RUN;
            cnt      <= '0;
            pc_sel   <= PCSEL_SEQ;
            if_flush <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state    <= ST_RUN;
          cnt      <= '0;
          pc_sel   <= PCSEL_SEQ;
          if_flush <= 1'b0;
        end
      endcase
    end
  end

  // Only ops that would actually issue are reported; wrong-path garbage is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_err  <= 1'b0;
      illegal_slot <= '0;
    end else if (!illegal_err && !stall && !ex_br_taken && state == ST_RUN && ill_hit) begin
      illegal_err  <= 1'b1;
      illegal_slot <= ill_idx;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign fsm_state = state;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_out
    assign ex_regwrite[g]          = ex_q[g].regwrite;
    assign ex_memwrite[g]          = ex_q[g].memwrite;
    assign ex_memread[g]           = ex_q[g].memread;
    assign ex_jump[g]              = ex_q[g].jump;
    assign ex_branch[g]            = ex_q[g].branch;
    assign ex_slti[g]              = ex_q[g].slti;
    assign ex_aluop[2*g +: 2]      = ex_q[g].aluop;
    assign ex_alusrcb[3*g +: 3]    = ex_q[g].alusrcb;
    assign ex_memtoreg[2*g +: 2]   = ex_q[g].memtoreg;
  end

endmodule

// File: tb/tb_vliw_ctrl_stage.sv
// Directed bench for vliw_ctrl_stage (2 slots, slot 1 compressed, 1-cycle flush).
module tb_vliw_ctrl_stage;

  logic        clk;
  logic        rst_n;
  logic [1:0]  id_valid;
  logic [13:0] id_opcode;
  logic [5:0]  id_funct3;
  logic        stall;
  logic        ex_br_taken;
  logic [1:0]  ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_jump, ex_branch, ex_slti;
  logic [3:0]  ex_aluop;
  logic [5:0]  ex_alusrcb;
  logic [3:0]  ex_memtoreg;
  logic [1:0]  pc_sel;
  logic        if_flush;
  logic        illegal_err;
  logic [0:0]  illegal_slot;
  logic        fsm_state;

  int checks;
  int failures;

  vliw_ctrl_stage #(.NUM_SLOTS(2), .COMP_MASK(2'b10), .FLUSH_CYCLES(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_funct3    (id_funct3),
    .stall        (stall),
    .ex_br_taken  (ex_br_taken),
    .ex_valid     (ex_valid),
    .ex_regwrite  (ex_regwrite),
    .ex_memwrite  (ex_memwrite),
    .ex_memread   (ex_memread),
    .ex_jump      (ex_jump),
    .ex_branch    (ex_branch),
    .ex_slti      (ex_slti),
    .ex_aluop     (ex_aluop),
    .ex_alusrcb   (ex_alusrcb),
    .ex_memtoreg  (ex_memtoreg),
    .pc_sel       (pc_sel),
    .if_flush     (if_flush),
    .illegal_err  (illegal_err),
    .illegal_slot (illegal_slot),
    .fsm_state    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [6:0] op, input logic [2:0] f3);
    id_opcode[7*s +: 7] = op;
    id_funct3[3*s +: 3] = f3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 2'b00; id_opcode = '0; id_funct3 = '0;
    stall = 1'b0; ex_br_taken = 1'b0;
    #12;
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL reset_ex_valid got=%b exp=00", ex_valid); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL reset_pc_sel got=%b exp=00", pc_sel); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL reset_if_flush got=%b exp=0", if_flush); end
    checks++; if (illegal_err !== 1'b0) begin failures++; $display("FAIL reset_illegal_err got=%b exp=0", illegal_err); end
    checks++; if (ex_regwrite !== 2'b00) begin failures++; $display("FAIL reset_regwrite got=%b exp=00", ex_regwrite); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_dual_issue();
    set_slot(0, 7'b0010011, 3'b000);   // addi
    set_slot(1, 7'b0000000, 3'b010);   // c.lw
    id_valid = 2'b11;
    step();
    checks++; if (ex_valid !== 2'b11) begin failures++; $display("FAIL dual_valid got=%b exp=11", ex_valid); end
    checks++; if (ex_aluop[1:0] !== 2'b00) begin failures++; $display("FAIL dual_aluop0 got=%b exp=00", ex_aluop[1:0]); end
    checks++; if (ex_alusrcb[2:0] !== 3'b010) begin failures++; $display("FAIL dual_srcb0 got=%b exp=010", ex_alusrcb[2:0]); end
    checks++; if (ex_memread !== 2'b10) begin failures++; $display("FAIL dual_memread got=%b exp=10", ex_memread); end
    checks++; if (ex_memtoreg[3:2] !== 2'b10) begin failures++; $display("FAIL dual_memtoreg1 got=%b exp=10", ex_memtoreg[3:2]); end
    checks++; if (ex_regwrite !== 2'b11) begin failures++; $display("FAIL dual_regwrite got=%b exp=11", ex_regwrite); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL dual_pc_sel got=%b exp=00", pc_sel); end
    id_valid = 2'b00;
    step();
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL dual_drain got=%b exp=00", ex_valid); end
  endtask

  task automatic test_jump_squash();
    set_slot(0, 7'b1100111, 3'b000);   // jalr
    set_slot(1, 7'b0000001, 3'b011);   // c.lui
    id_valid = 2'b11;
    step();
    checks++; if (ex_valid !== 2'b01) begin failures++; $display("FAIL jump_valid got=%b exp=01", ex_valid); end
    checks++; if (ex_jump !== 2'b01) begin failures++; $display("FAIL jump_jump got=%b exp=01", ex_jump); end
    checks++; if (ex_memtoreg[1:0] !== 2'b01) begin failures++; $display("FAIL jump_memtoreg0 got=%b exp=01", ex_memtoreg[1:0]); end
    checks++; if (ex_alusrcb[2:0] !== 3'b100) begin failures++; $display("FAIL jump_srcb0 got=%b exp=100", ex_alusrcb[2:0]); end
    checks++; if (ex_regwrite !== 2'b01) begin failures++; $display("FAIL jump_regwrite got=%b exp=01", ex_regwrite); end
    checks++; if (pc_sel !== 2'b10) begin failures++; $display("FAIL jump_pc_sel got=%b exp=10", pc_sel); end
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL jump_if_flush got=%b exp=1", if_flush); end
    set_slot(0, 7'b0010011, 3'b000);   // addi arriving in flush window
    step();
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL flushwin_valid got=%b exp=00", ex_valid); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL flushwin_end got=%b exp=0", if_flush); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL flushwin_pc_sel got=%b exp=00", pc_sel); end
    step();
    checks++; if (ex_valid !== 2'b11) begin failures++; $display("FAIL postflush_valid got=%b exp=11", ex_valid); end
    checks++; if (ex_alusrcb !== 6'b010010) begin failures++; $display("FAIL postflush_srcb got=%b exp=010010", ex_alusrcb); end
    id_valid = 2'b00;
    step();
  endtask

  task automatic test_stall_hold();
    set_slot(0, 7'b0110011, 3'b100);   // xor
    id_valid = 2'b01;
    step();
    checks++; if (ex_aluop[1:0] !== 2'b01) begin failures++; $display("FAIL xor_aluop got=%b exp=01", ex_aluop[1:0]); end
    stall = 1'b1;
    set_slot(0, 7'b0010011, 3'b010);   // slti
    set_slot(1, 7'b0000000, 3'b010);   // c.lw
    id_valid = 2'b11;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (ex_valid !== 2'b01) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=01", c, ex_valid); end
      checks++; if (ex_aluop !== 4'b0001) begin failures++; $display("FAIL stall_aluop cyc=%0d got=%b exp=0001", c, ex_aluop); end
    end
    stall = 1'b0;
    step();
    checks++; if (ex_valid !== 2'b11) begin failures++; $display("FAIL release_valid got=%b exp=11", ex_valid); end
    checks++; if (ex_slti !== 2'b01) begin failures++; $display("FAIL release_slti got=%b exp=01", ex_slti); end
    checks++; if (ex_aluop[1:0] !== 2'b11) begin failures++; $display("FAIL release_aluop0 got=%b exp=11", ex_aluop[1:0]); end
  endtask

  task automatic test_collision();
    set_slot(0, 7'b1100111, 3'b000);   // jalr waiting in ID
    id_valid = 2'b01;
    stall = 1'b1;
    ex_br_taken = 1'b1;
    step();
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL coll_valid got=%b exp=00", ex_valid); end
    checks++; if (ex_jump !== 2'b00) begin failures++; $display("FAIL coll_jump got=%b exp=00", ex_jump); end
    checks++; if (pc_sel !== 2'b01) begin failures++; $display("FAIL coll_pc_sel got=%b exp=01", pc_sel); end
    checks++; if (if_flush !== 1'b1) begin failures++; $display("FAIL coll_if_flush got=%b exp=1", if_flush); end
    ex_br_taken = 1'b0;
    stall = 1'b0;
    step();
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL coll_jalr_dropped got=%b exp=00", ex_valid); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL coll_pc_back got=%b exp=00", pc_sel); end
    id_valid = 2'b00;
    step();
  endtask

  task automatic test_illegal();
    checks++; if (illegal_err !== 1'b0) begin failures++; $display("FAIL ill_pre got=%b exp=0", illegal_err); end
    set_slot(0, 7'b0010011, 3'b000);   // addi
    set_slot(1, 7'b1111111, 3'b000);   // bad quadrant
    id_valid = 2'b11;
    step();
    checks++; if (ex_valid !== 2'b01) begin failures++; $display("FAIL ill1_valid got=%b exp=01", ex_valid); end
    checks++; if (illegal_err !== 1'b1) begin failures++; $display("FAIL ill1_err got=%b exp=1", illegal_err); end
    checks++; if (illegal_slot !== 1'b1) begin failures++; $display("FAIL ill1_slot got=%b exp=1", illegal_slot); end
    set_slot(0, 7'b1111111, 3'b000);   // bad full opcode
    set_slot(1, 7'b0000000, 3'b010);   // c.lw, squashed behind it
    step();
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL ill2_valid got=%b exp=00", ex_valid); end
    checks++; if (ex_regwrite !== 2'b00) begin failures++; $display("FAIL ill2_regwrite got=%b exp=00", ex_regwrite); end
    checks++; if (illegal_slot !== 1'b1) begin failures++; $display("FAIL ill2_slot_kept got=%b exp=1", illegal_slot); end
    id_valid = 2'b00;
    step();
  endtask

  task automatic test_reset_mid_flush();
    set_slot(0, 7'b1100111, 3'b000);   // jalr
    id_valid = 2'b01;
    step();
    checks++; if (fsm_state !== 1'b1) begin failures++; $display("FAIL rmid_in_flush got=%b exp=1", fsm_state); end
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 2'b00) begin failures++; $display("FAIL rmid_valid got=%b exp=00", ex_valid); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL rmid_if_flush got=%b exp=0", if_flush); end
    checks++; if (pc_sel !== 2'b00) begin failures++; $display("FAIL rmid_pc_sel got=%b exp=00", pc_sel); end
    checks++; if (illegal_err !== 1'b0) begin failures++; $display("FAIL rmid_illegal got=%b exp=0", illegal_err); end
    checks++; if (ex_jump !== 2'b00) begin failures++; $display("FAIL rmid_jump got=%b exp=00", ex_jump); end
    #2;
    rst_n = 1'b1;
    stall = 1'b0;
    id_valid = 2'b00;
    step();
    checks++; if (fsm_state !== 1'b0) begin failures++; $display("FAIL rmid_run got=%b exp=0", fsm_state); end
    checks++; if (if_flush !== 1'b0) begin failures++; $display("FAIL rmid_after_flush got=%b exp=0", if_flush); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_dual_issue();
    test_jump_squash();
    test_stall_hold();
    test_collision();
    test_illegal();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
